// File: rtl/delay_param_ctrl.sv
// delay_param_ctrl: moves blend/delay/feedbk toward their targets on sample ticks,
// gliding small delay changes and ducking blend around large delay jumps.
module delay_param_ctrl #(
    parameter int BLEND_B   = 10,
    parameter int DLY_B     = 14,
    parameter int FDB_B     = 10,
    parameter int DLY_STEP  = 1,
    parameter int JUMP_TH   = 256,
    parameter int DUCK_STEP = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_sel,
    input  logic [15:0]        cfg_data,
    output logic [BLEND_B-1:0] blend,
    output logic [DLY_B-1:0]   delay,
    output logic [FDB_B-1:0]   feedbk,
    output logic               busy
);
    localparam logic [DLY_B:0]   STEP_W = (DLY_B+1)'(DLY_STEP);
    localparam logic [DLY_B:0]   JUMP_W = (DLY_B+1)'(JUMP_TH);
    localparam logic [BLEND_B:0] DUCK_W = (BLEND_B+1)'(DUCK_STEP);

    typedef enum logic [2:0] {IDLE, RAMP, DUCK_DOWN, JUMP, DUCK_UP} state_t;

    state_t             state, state_nx;
    logic [BLEND_B-1:0] blend_tgt, blend_nx;
    logic [DLY_B-1:0]   delay_tgt, delay_nx;
    logic [FDB_B-1:0]   feedbk_tgt;
    logic [DLY_B:0]     d, step, ramped;
    logic [BLEND_B:0]   bl_dn, bl_sum, bl_up;
    logic               up, accept, unused_bits;

    assign cfg_ready   = state != JUMP;
    assign accept      = cfg_valid && cfg_ready;
    assign busy        = state != IDLE || blend != blend_tgt || delay != delay_tgt || feedbk != feedbk_tgt;
    assign unused_bits = &{1'b0, cfg_data, ramped[DLY_B], bl_up[BLEND_B]};

    always_comb begin
        up       = delay_tgt > delay;
        d        = up ? {1'b0, delay_tgt} - {1'b0, delay} : {1'b0, delay} - {1'b0, delay_tgt};
        step     = d < STEP_W ? d : STEP_W;
        ramped   = up ? {1'b0, delay} + step : {1'b0, delay} - step;
        bl_dn    = {1'b0, blend} > DUCK_W ? {1'b0, blend} - DUCK_W : '0;
        bl_sum   = {1'b0, blend} + DUCK_W;
        // min() also covers a blend target that dropped below the current blend
        bl_up    = bl_sum > {1'b0, blend_tgt} ? {1'b0, blend_tgt} : bl_sum;
        state_nx = state;
        blend_nx = blend;
        delay_nx = delay;
        if (sample_tick)
            case (state)
                IDLE, RAMP: begin
                    blend_nx = blend_tgt;
                    delay_nx = d > JUMP_W ? delay : ramped[DLY_B-1:0];
                    state_nx = d > JUMP_W ? DUCK_DOWN : d != step ? RAMP : IDLE;
                end
                DUCK_DOWN: begin
                    blend_nx = bl_dn[BLEND_B-1:0];
                    state_nx = bl_dn == '0 ? JUMP : DUCK_DOWN;
                end
                JUMP: begin
                    delay_nx = delay_tgt;
                    state_nx = DUCK_UP;
                end
                DUCK_UP: begin
                    blend_nx = bl_up[BLEND_B-1:0];
                    state_nx = bl_up[BLEND_B-1:0] == blend_tgt ? IDLE : DUCK_UP;
                end
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            blend      <= '0;
            delay      <= '0;
            feedbk     <= '0;
            blend_tgt  <= '0;
            delay_tgt  <= '0;
            feedbk_tgt <= '0;
        end else begin
            state <= state_nx;
            blend <= blend_nx;
            delay <= delay_nx;
            if (sample_tick)
                feedbk <= feedbk_tgt;
            if (accept && cfg_sel == 2'd0)
                blend_tgt <= cfg_data[BLEND_B-1:0];
            if (accept && cfg_sel == 2'd1)
                delay_tgt <= cfg_data[DLY_B-1:0];
            if (accept && cfg_sel == 2'd2)
                feedbk_tgt <= cfg_data[FDB_B-1:0];
        end
    end
endmodule
